// File: rtl/iq_integrator.sv
// Readout I/Q integrator: after a trigger, skips delay_len valid samples, then mixes
// int_len samples against the LO references, accumulates, scales and saturates to 32 bits.
module iq_integrator #(
   parameter int ACC_W  = 48,
   parameter int SAMP_W = 16
) (
   input  logic                     clk100,
   input  logic                     rst_n,
   input  logic                     trigger,
   input  logic [15:0]              delay_len,
   input  logic [15:0]              int_len,
   input  logic [4:0]               shift,
   input  logic                     sample_valid,
   input  logic signed [SAMP_W-1:0] adc_sample,
   input  logic signed [SAMP_W-1:0] lo_cos,
   input  logic signed [SAMP_W-1:0] lo_sin,
   output logic signed [31:0]       i_val,
   output logic signed [31:0]       q_val,
   output logic                     iq_valid,
   output logic                     busy,
   output logic                     overrun
);
   localparam int PROD_W = 2 * SAMP_W;

   typedef enum logic [1:0] {IDLE, DELAY, INTEG, FLUSH} state_t;

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg;
   logic [15:0] delay_len_reg;
   logic [15:0] int_len_reg;
   logic [4:0]  shift_reg;
   logic        prod_valid_reg;
   logic [16:0] cnt_inc;
   logic        start, skip, take, last_skip, emit;

   assign cnt_inc = {1'b0, cnt_reg} + 17'd1;
   assign busy    = (state_reg != IDLE);

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      skip       = 1'b0;
      take       = 1'b0;
      last_skip  = 1'b0;
      emit       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trigger) begin
               start      = 1'b1;
               state_next = (delay_len == 16'd0) ? INTEG : DELAY;
            end
         end
         DELAY: begin
            if (sample_valid) begin
               skip = 1'b1;
               if (cnt_inc == {1'b0, delay_len_reg}) begin
                  last_skip  = 1'b1;
                  state_next = INTEG;
               end
            end
         end
         INTEG: begin
            if (sample_valid) begin
               take = 1'b1;
               if (cnt_inc == {1'b0, int_len_reg}) state_next = FLUSH;
            end
         end
         FLUSH: begin
            // one extra cycle while the last product is still entering the accumulator
            if (!prod_valid_reg) begin
               emit       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         delay_len_reg  <= '0;
         int_len_reg    <= '0;
         shift_reg      <= '0;
         prod_valid_reg <= 1'b0;
         iq_valid       <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (start) begin
            delay_len_reg <= delay_len;
            int_len_reg   <= (int_len == 16'd0) ? 16'd1 : int_len;
            shift_reg     <= shift;
            cnt_reg       <= '0;
         end else if (last_skip) begin
            cnt_reg <= '0;
         end else if (skip || take) begin
            cnt_reg <= cnt_inc[15:0];
         end
         prod_valid_reg <= take;
         iq_valid       <= emit;
         overrun        <= trigger && (state_reg != IDLE);
      end
   end

   function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] v);
      if ((&v[ACC_W-1:31]) || !(|v[ACC_W-1:31])) return v[31:0];
      else if (v[ACC_W-1])                       return 32'sh8000_0000;
      else                                       return 32'sh7FFF_FFFF;
   endfunction

   logic signed [SAMP_W-1:0] lo_ref [2];
   logic signed [PROD_W-1:0] adc_ext;

   assign lo_ref[0] = lo_cos;
   assign lo_ref[1] = lo_sin;
   assign adc_ext   = {{SAMP_W{adc_sample[SAMP_W-1]}}, adc_sample};

   // channel 0 is I (cos), channel 1 is Q (sin)
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic signed [PROD_W-1:0] lo_ext;
         logic signed [PROD_W-1:0] prod_reg;
         logic signed [ACC_W-1:0]  acc_reg;
         logic signed [ACC_W-1:0]  acc_sh;
         logic signed [31:0]       res_reg;

         assign lo_ext = {{SAMP_W{lo_ref[gi][SAMP_W-1]}}, lo_ref[gi]};
         assign acc_sh = acc_reg >>> shift_reg;

         always_ff @(posedge clk100 or negedge rst_n) begin
            if (!rst_n) begin
               prod_reg <= '0;
               acc_reg  <= '0;
               res_reg  <= '0;
            end else begin
               if (take) prod_reg <= adc_ext * lo_ext;
               if (start)
                  acc_reg <= '0;
               else if (prod_valid_reg)
                  acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
               if (emit) res_reg <= sat32(acc_sh);
            end
         end
      end
   endgenerate

   assign i_val = g_chan[0].res_reg;
   assign q_val = g_chan[1].res_reg;

endmodule

// File: tb/tb_iq_integrator.sv
// Bench for iq_integrator: directed scenarios plus random windows, every cycle compared
// against a window-level reference model (skip N valid samples, sum M products, scale, clamp).
module tb_iq_integrator;

   logic        clk100 = 1'b0;
   logic        rst_n;
   logic        trigger;
   logic [15:0] delay_len;
   logic [15:0] int_len;
   logic [4:0]  shift;
   logic        sample_valid;
   logic [15:0] adc_sample;
   logic [15:0] lo_cos;
   logic [15:0] lo_sin;
   logic [31:0] i_val;
   logic [31:0] q_val;
   logic        iq_valid;
   logic        busy;
   logic        overrun;

   always #5 clk100 = ~clk100;

   iq_integrator dut (
      .clk100       (clk100),
      .rst_n        (rst_n),
      .trigger      (trigger),
      .delay_len    (delay_len),
      .int_len      (int_len),
      .shift        (shift),
      .sample_valid (sample_valid),
      .adc_sample   (adc_sample),
      .lo_cos       (lo_cos),
      .lo_sin       (lo_sin),
      .i_val        (i_val),
      .q_val        (q_val),
      .iq_valid     (iq_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h (%0d) exp=0x%08h (%0d)", tag, got, $signed(got), exp, $signed(exp));
      end
   endtask

   // reference model: one window = skip, collect, then result two edges after the last sample
   bit          m_active;
   int          m_skip, m_take, m_out, m_sh;
   longint      m_si, m_sq;
   logic [31:0] m_i, m_q;
   int          edge_n;
   int          n_iqv, n_ovr, n_txn;

   function automatic logic [31:0] scale(input longint acc, input int sh);
      longint v;
      v = acc >>> sh;
      if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
      return v[31:0];
   endfunction

   task automatic step(input bit trig, input bit vld, input int adc, input int c, input int s);
      bit exp_valid, exp_ovr;
      trigger      = trig;
      sample_valid = vld;
      adc_sample   = adc[15:0];
      lo_cos       = c[15:0];
      lo_sin       = s[15:0];
      @(posedge clk100);
      edge_n++;
      exp_valid = 1'b0;
      exp_ovr   = trig && m_active;
      if (m_active) begin
         if (m_out == edge_n) begin
            m_i       = scale(m_si, m_sh);
            m_q       = scale(m_sq, m_sh);
            m_active  = 1'b0;
            exp_valid = 1'b1;
         end else if (m_out < 0 && vld) begin
            if (m_skip > 0) m_skip--;
            else begin
               m_si += longint'(adc) * longint'(c);
               m_sq += longint'(adc) * longint'(s);
               m_take--;
               if (m_take == 0) m_out = edge_n + 2;
            end
         end
      end else if (trig) begin
         m_active = 1'b1;
         m_skip   = int'(delay_len);
         m_take   = (int_len == 16'd0) ? 1 : int'(int_len);
         m_sh     = int'(shift);
         m_si     = 0;
         m_sq     = 0;
         m_out    = -1;
      end
      #1;
      if (iq_valid) begin
         n_iqv++;
         n_txn++;
         $display("txn %0d: t=%0t i_val=%0d q_val=%0d", n_txn, $time, $signed(i_val), $signed(q_val));
      end
      if (overrun) n_ovr++;
      check("iq_valid", {31'b0, iq_valid}, {31'b0, exp_valid});
      check("busy",     {31'b0, busy},     {31'b0, m_active});
      check("overrun",  {31'b0, overrun},  {31'b0, exp_ovr});
      check("i_val",    i_val, m_i);
      check("q_val",    q_val, m_q);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_i"},    i_val, 32'd0);
      check({tag, "_q"},    q_val, 32'd0);
      check({tag, "_vld"},  {31'b0, iq_valid}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_ovr"},  {31'b0, overrun}, 32'd0);
   endtask

   // reset is asserted between edges so its asynchronous effect is visible before any clock
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_cleared("rst_async");
      repeat (2) begin
         @(posedge clk100);
         edge_n++;
         #1;
         check_cleared("rst_hold");
      end
      rst_n    = 1'b1;
      m_active = 1'b0;
      m_i      = '0;
      m_q      = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic setup(input int d, input int n, input int sh);
      delay_len = 16'(d);
      int_len   = 16'(n);
      shift     = 5'(sh);
   endtask

   int pulses0, ovr0;

   initial begin
      rst_n = 1'b1;
      trigger = 1'b0; sample_valid = 1'b0;
      adc_sample = '0; lo_cos = '0; lo_sin = '0;
      setup(0, 0, 0);
      m_active = 1'b0; m_i = '0; m_q = '0; m_out = -1;
      edge_n = 0; n_iqv = 0; n_ovr = 0; n_txn = 0;
      #2;
      do_reset();
      idle(2);

      // basic integration
      setup(0, 4, 0);
      pulses0 = n_iqv;
      step(1'b1, 1'b1, 1000, 16384, 0);
      repeat (8) step(1'b0, 1'b1, 1000, 16384, 0);
      check("basic_i", i_val, 32'd65536000);
      check("basic_q", q_val, 32'd0);
      check("basic_pulses", 32'(n_iqv - pulses0), 32'd1);
      idle(2);

      // delay with gapped samples: samples 4 and 5 are integrated
      setup(3, 2, 0);
      step(1'b1, 1'b1, 99, 1, -1);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b1, k, 1, -1);
         step(1'b0, 1'b0, 0, 1, -1);
      end
      check("gap_i", i_val, 32'd9);
      check("gap_q", q_val, 32'hFFFF_FFF7);
      idle(2);

      // saturation, then shift
      for (int pass = 0; pass < 2; pass++) begin
         setup(0, 4, pass * 2);
         step(1'b1, 1'b0, 0, 0, 0);
         repeat (6) step(1'b0, 1'b1, -32768, -32768, 32767);
         idle(2);
         check(pass == 0 ? "sat_i" : "shift_i", i_val, pass == 0 ? 32'h7FFF_FFFF : 32'd1073741824);
      end

      // overrun: second trigger mid-window
      setup(0, 4, 0);
      pulses0 = n_iqv;
      ovr0    = n_ovr;
      step(1'b1, 1'b0, 0, 0, 0);
      step(1'b0, 1'b1, 1000, 16384, 0);
      step(1'b1, 1'b1, 1000, 16384, 0);
      repeat (6) step(1'b0, 1'b1, 1000, 16384, 0);
      check("ovr_i", i_val, 32'd65536000);
      check("ovr_pulses", 32'(n_iqv - pulses0), 32'd1);
      check("ovr_count", 32'(n_ovr - ovr0), 32'd1);
      idle(2);

      // reset mid-window, then a clean basic run
      setup(0, 4, 0);
      step(1'b1, 1'b0, 0, 0, 0);
      repeat (2) step(1'b0, 1'b1, 1000, 16384, 0);
      pulses0 = n_iqv;
      do_reset();
      idle(5);
      check("rst_no_stale", 32'(n_iqv - pulses0), 32'd0);
      step(1'b1, 1'b0, 0, 0, 0);
      repeat (8) step(1'b0, 1'b1, 1000, 16384, 0);
      check("rst_rerun_i", i_val, 32'd65536000);
      idle(2);

      // int_len=0 behaves as a single sample
      setup(0, 0, 0);
      step(1'b1, 1'b0, 0, 0, 0);
      repeat (5) step(1'b0, 1'b1, 7, 3, 0);
      check("len0_i", i_val, 32'd21);
      idle(2);

      // random windows with gaps, stray triggers and register changes mid-window
      for (int w = 0; w < 30; w++) begin
         setup($urandom_range(0, 4), $urandom_range(0, 6),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 12));
         for (int c = 0; c < 30; c++) begin
            if (c == 10) setup($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 31));
            step((c == 0) || ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);
         end
      end
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
